muldiv_seq: RTL and testbench

Iterative multiply/divide sequencer that owns the HI/LO register pair of the MIPS pipeline. It accepts mult/multu/div/divu/mthi/mtlo from the EX stage, runs a radix-2 shift-add or restoring-divide loop, and drives a stall request toward the pipeline control logic. The stall is raised while a decode-stage instruction needs HI/LO or the unit itself before the running operation has retired. It sits beside the ALU in EX and feeds mfhi/mflo results back into the EX result mux.

---
 rtl/muldiv_pkg.sv | 22 ++
 rtl/muldiv_core.sv | 39 +++
 rtl/muldiv_seq.sv | 188 ++++++++++++++++++
 tb/tb_muldiv_seq.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings for the HI/LO multiply/divide sequencer.
package muldiv_pkg;

  localparam int unsigned DefaultWidth = 32;

  typedef enum logic [2:0] {
    OpMult  = 3'd0,
    OpMultu = 3'd1,
    OpDiv   = 3'd2,
    OpDivu  = 3'd3,
    OpMthi  = 3'd4,
    OpMtlo  = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StPrep = 2'd1,
    StRun  = 2'd2,
    StFix  = 2'd3
  } state_e;

endpackage

// File: rtl/muldiv_core.sv
// One radix-2 iteration: shift-add multiply step or restoring-divide step.
module muldiv_core
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic                 is_div,
  input  logic [2*WIDTH-1:0]   acc,
  input  logic [WIDTH-1:0]     rem,
  input  logic [WIDTH-1:0]     opb,
  output logic [2*WIDTH-1:0]   acc_next,
  output logic [WIDTH-1:0]     rem_next
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;

  always_comb begin
    // Multiply: upper half accumulates, multiplier sits in the low half and shifts out.
    sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
    // Divide: dividend bits leave the low half MSB-first, quotient bits enter at the LSB.
    shifted = {rem, acc[WIDTH-1]};
    diff    = {1'b0, shifted} - {2'b00, opb};
    if (is_div) begin
      if (diff[WIDTH+1]) begin
        rem_next = shifted[WIDTH-1:0];
        acc_next = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-2:0], 1'b0};
      end else begin
        rem_next = diff[WIDTH-1:0];
        acc_next = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-2:0], 1'b1};
      end
    end else begin
      rem_next = rem;
      acc_next = {sum, acc[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative mult/div sequencer owning HI/LO; stalls decode while busy.
// Optional MULDIV_EARLY_OUT_EN: unsigned multiply retires once remaining multiplier bits are zero.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_E,
  input  logic [2:0]       op_E,
  input  logic [WIDTH-1:0] a_E,
  input  logic [WIDTH-1:0] b_E,
  input  logic             use_hilo_D,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CntW = $clog2(WIDTH);

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   opa_q, opa_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic               is_div_q, is_div_d;
  logic               neg_lo_q, neg_lo_d;
  logic               neg_rem_q, neg_rem_d;
  logic               dbz_q, dbz_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;
`ifdef MULDIV_EARLY_OUT_EN
  logic               is_multu_q, is_multu_d;
  logic [WIDTH-1:0]   left_mask;
`endif

  op_e                op;
  logic               is_signed;
  logic [WIDTH-1:0]   a_abs, b_abs;
  logic [2*WIDTH-1:0] core_acc;
  logic [WIDTH-1:0]   core_rem;
  logic [2*WIDTH-1:0] prod_fix;

  assign op        = op_e'(op_E);
  assign is_signed = (op == OpMult) || (op == OpDiv);
  assign a_abs     = (is_signed && a_E[WIDTH-1]) ? -a_E : a_E;
  assign b_abs     = (is_signed && b_E[WIDTH-1]) ? -b_E : b_E;
  assign prod_fix  = neg_lo_q ? -acc_q : acc_q;

  muldiv_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .is_div  (is_div_q),
    .acc     (acc_q),
    .rem     (rem_q),
    .opb     (opb_q),
    .acc_next(core_acc),
    .rem_next(core_rem)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    rem_d     = rem_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    is_div_d  = is_div_q;
    neg_lo_d  = neg_lo_q;
    neg_rem_d = neg_rem_q;
    dbz_d     = dbz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
`ifdef MULDIV_EARLY_OUT_EN
    is_multu_d = is_multu_q;
    // Multiplier bits still unconsumed after the current step.
    left_mask  = {WIDTH{1'b1}} >> (32'(cnt_q) + 32'd1);
`endif
    unique case (state_q)
      StIdle: begin
        if (start_E) begin
          unique case (op)
            OpMthi: hi_d = a_E;
            OpMtlo: lo_d = a_E;
            OpMult, OpMultu, OpDiv, OpDivu: begin
              opa_d     = a_abs;
              opb_d     = b_abs;
              is_div_d  = (op == OpDiv) || (op == OpDivu);
              neg_lo_d  = is_signed && (a_E[WIDTH-1] ^ b_E[WIDTH-1]);
              neg_rem_d = (op == OpDiv) && a_E[WIDTH-1];
              dbz_d     = ((op == OpDiv) || (op == OpDivu)) && (b_E == '0);
`ifdef MULDIV_EARLY_OUT_EN
              is_multu_d = (op == OpMultu);
`endif
              state_d   = StPrep;
            end
            default: ;
          endcase
        end
      end
      StPrep: begin
        acc_d   = {{WIDTH{1'b0}}, opa_q};
        rem_d   = '0;
        cnt_d   = '0;
        state_d = StRun;
      end
      StRun: begin
        acc_d = core_acc;
        rem_d = core_rem;
        if (cnt_q == CntW'(WIDTH - 1)) begin
          state_d = StFix;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`ifdef MULDIV_EARLY_OUT_EN
        if (is_multu_q && ((core_acc[WIDTH-1:0] & left_mask) == '0)) begin
          acc_d   = core_acc >> (CntW'(WIDTH - 1) - cnt_q);
          state_d = StFix;
        end
`endif
      end
      StFix: begin
        if (is_div_q) begin
          // Divide by zero leaves |dividend| in rem; the dividend-sign fix restores it as given.
          lo_d = dbz_q ? {WIDTH{1'b1}} : (neg_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
          hi_d = neg_rem_q ? -rem_q : rem_q;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      acc_q     <= '0;
      rem_q     <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      is_div_q  <= 1'b0;
      neg_lo_q  <= 1'b0;
      neg_rem_q <= 1'b0;
      dbz_q     <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
`ifdef MULDIV_EARLY_OUT_EN
      is_multu_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      rem_q     <= rem_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      is_div_q  <= is_div_d;
      neg_lo_q  <= neg_lo_d;
      neg_rem_q <= neg_rem_d;
      dbz_q     <= dbz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
`ifdef MULDIV_EARLY_OUT_EN
      is_multu_q <= is_multu_d;
`endif
    end
  end

  assign busy  = (state_q != StIdle);
  assign stall = busy & use_hilo_D;
  assign done  = done_q;
  assign hi    = hi_q;
  assign lo    = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed self-checking bench for muldiv_seq (default fixed-latency build).
module tb_muldiv_seq;

  localparam int unsigned W = 32;

  logic         clk;
  logic         rst;
  logic         start_E;
  logic [2:0]   op_E;
  logic [W-1:0] a_E;
  logic [W-1:0] b_E;
  logic         use_hilo_D;
  logic         stall;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int n_cmp = 0;
  int n_err = 0;

  muldiv_seq #(
    .WIDTH(W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start_E   (start_E),
    .op_E      (op_E),
    .a_E       (a_E),
    .b_E       (b_E),
    .use_hilo_D(use_hilo_D),
    .stall     (stall),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one mult/div, wait for done, check latency, results and single-cycle done.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp_hi,
                        input logic [W-1:0] exp_lo);
    int cyc;
    @(negedge clk);
    start_E = 1'b1;
    op_E    = op;
    a_E     = a;
    b_E     = b;
    @(posedge clk);
    #1 start_E = 1'b0;
    cyc = 0;
    while (!done && cyc < 100) begin
      @(posedge clk);
      #1 cyc++;
    end
    check({tag, "_lat"}, 64'(cyc), 64'd34);
    check({tag, "_hi"}, 64'(hi), 64'(exp_hi));
    check({tag, "_lo"}, 64'(lo), 64'(exp_lo));
    @(posedge clk);
    #1 check({tag, "_done_once"}, 64'(done), 64'd0);
  endtask

  initial begin
    int n_stall;
    rst        = 1'b1;
    start_E    = 1'b0;
    op_E       = 3'd0;
    a_E        = '0;
    b_E        = '0;
    use_hilo_D = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_stall", 64'(stall), 64'd0);
    rst = 1'b0;

    run_op("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("mult_neg", 3'd0, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_op("mult_min", 3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
    run_op("div_neg", 3'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu", 3'd3, 32'd100, 32'd7, 32'd2, 32'd14);
    run_op("divu_zero", 3'd3, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF);
    run_op("div_zero", 3'd2, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
    run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);

    // Stall window: decode wants HI/LO from the cycle after start.
    @(negedge clk);
    start_E = 1'b1;
    op_E    = 3'd1;
    a_E     = 32'd3;
    b_E     = 32'd5;
    @(posedge clk);
    #1 start_E = 1'b0;
    use_hilo_D = 1'b1;
    n_stall = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (stall) n_stall++;
      if (done) begin
        check("stall_at_done", 64'(stall), 64'd0);
        check("stall_lo", 64'(lo), 64'd15);
      end
    end
    check("stall_cycles", 64'(n_stall), 64'd34);

    // MTHI in idle with decode using HI/LO: no stall, visible next cycle.
    @(negedge clk);
    start_E = 1'b1;
    op_E    = 3'd4;
    a_E     = 32'h0000_1234;
    #1 check("mthi_no_stall", 64'(stall), 64'd0);
    @(posedge clk);
    #1 start_E = 1'b0;
    check("mthi_hi", 64'(hi), 64'h1234);
    check("mthi_busy", 64'(busy), 64'd0);

    // Async reset during RUN iteration 10.
    @(negedge clk);
    start_E = 1'b1;
    op_E    = 3'd1;
    a_E     = 32'hFFFF_FFFF;
    b_E     = 32'hFFFF_FFFF;
    @(posedge clk);
    #1 start_E = 1'b0;
    repeat (11) @(posedge clk);
    #1 check("pre_rst_stall", 64'(stall), 64'd1);
    rst = 1'b1;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_stall", 64'(stall), 64'd0);
    check("abort_hi", 64'(hi), 64'd0);
    check("abort_lo", 64'(lo), 64'd0);
    @(negedge clk);
    rst        = 1'b0;
    use_hilo_D = 1'b0;
    run_op("multu_after_rst", 3'd1, 32'd6, 32'd7, 32'd0, 32'd42);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
